odom_scheduler: RTL
===================

// Module: odom_scheduler
// PURPOSE
//  Sequences the odometry datapath at a fixed sample rate: latches wheel speeds, starts the global-velocity
//  rotation, waits for its done flag, then issues one integrate strobe to the position calculator.
//  Also turns the SETBEGIN button into a single position-clear pulse, and flags sample overruns and timeouts.
//  Sits beside the odometry calculator and drives its control inputs; the datapath is unchanged.
// PARAMETERS
//  PERIOD_CYCLES   500000  clocks per odometry sample (10 ms at 50 MHz), >= 8
//  PERIOD_WIDTH    20      width of period counter, 2^PERIOD_WIDTH > PERIOD_CYCLES
//  TIMEOUT_CYCLES  1000    max clocks in WAIT for GV done before abort, >= 2
//  TO_WIDTH        10      width of timeout counter, 2^TO_WIDTH >= TIMEOUT_CYCLES
//  CNT_WIDTH       16      width of completed-sample counter
// PORTS
//  ODOM_SCHEDULER_CLOCK_50        in   1   system clock, 50 MHz
//  ODOM_SCHEDULER_Reset_InLow     in   1   asynchronous, active-low reset
//  ODOM_SCHEDULER_ENABLE_InHigh   in   1   1 = generate sample ticks
//  ODOM_SCHEDULER_SETBEGIN_InLow  in   1   async button, falling edge requests position clear
//  ODOM_SCHEDULER_GV_DONE_In      in   1   done flag from global-velocity stage
//  ODOM_SCHEDULER_ERRCLR_InHigh   in   1   clears OVERRUN/TIMEOUT flags
//  ODOM_SCHEDULER_LATCH_Out       out  1   1-cycle strobe: capture W1..W4 and THETA
//  ODOM_SCHEDULER_GV_START_Out    out  1   1-cycle strobe: start global-velocity computation
//  ODOM_SCHEDULER_POS_UPDATE_Out  out  1   1-cycle strobe: integrate one step in position calculator
//  ODOM_SCHEDULER_POS_CLEAR_OutLow out 1   1-cycle low pulse: zero position/theta
//  ODOM_SCHEDULER_BUSY_Out        out  1   1 when state != IDLE
//  ODOM_SCHEDULER_OVERRUN_Out     out  1   sticky: tick dropped
//  ODOM_SCHEDULER_TIMEOUT_Out     out  1   sticky: GV done never arrived
//  ODOM_SCHEDULER_SAMPLE_COUNT_OutBus out CNT_WIDTH  completed samples, wraps
//  ODOM_SCHEDULER_STATE_OutBus    out  3   current state code (debug)
// BEHAVIOUR
//  Reset (async, low): state IDLE(0); LATCH/GV_START/POS_UPDATE=0; POS_CLEAR_OutLow=1; BUSY=0; flags=0;
//   SAMPLE_COUNT=0; period/timeout counters=0; SETBEGIN sync regs=1 (no false edge on release).
//   Reset mid-sequence aborts it immediately; no partial strobes follow release.
//  Period counter: ENABLE=1 counts 0..PERIOD_CYCLES-1 and wraps; tick = 1 cycle when count==PERIOD_CYCLES-1.
//   ENABLE=0 holds counter at 0, no ticks. In-flight sequence always completes. First tick PERIOD_CYCLES clocks after enable.
//  SETBEGIN: 2-FF synchronizer + falling-edge detect sets clear_pending. Holding low gives one request only.
//  FSM; all outputs decode the registered state (no combinational input-to-output paths):
//   IDLE(0):   clear_pending -> CLEAR; else tick -> LATCH. Tick coinciding with CLEAR is dropped and sets OVERRUN.
//   LATCH(1):  LATCH_Out=1 -> START.
//   START(2):  GV_START_Out=1; timeout counter cleared -> WAIT.
//   WAIT(3):   GV_DONE_In=1 -> UPDATE; else at timeout count==TIMEOUT_CYCLES-1 -> set TIMEOUT, -> IDLE.
//              A timeout issues no POS_UPDATE and leaves SAMPLE_COUNT unchanged.
//   UPDATE(4): POS_UPDATE_Out=1; SAMPLE_COUNT+1 (max wraps to 0) -> IDLE.
//   CLEAR(5):  POS_CLEAR_OutLow=0; SAMPLE_COUNT=0; clear_pending=0 -> IDLE.
//  Timing: tick at cycle T gives LATCH at T+1, GV_START at T+2, WAIT from T+3. DONE seen at cycle D in WAIT
//   gives POS_UPDATE at D+1. GV_DONE_In outside WAIT is ignored.
//  Tick while state != IDLE: tick dropped, OVERRUN set; no queued sample.
//  Clear request during a sequence is deferred: CLEAR runs after return to IDLE.
//  ERRCLR: clears both flags; if a set event occurs in the same cycle, set wins.
// TESTING
//  1 PERIOD=10, TIMEOUT=8, ENABLE=1, DONE 3 clk after START -> LATCH/START/UPDATE each 1 cycle, every 10 clk; COUNT 1,2,3.
//  2 DONE never returned -> TIMEOUT=1 8 clk after WAIT entry, no POS_UPDATE, COUNT held;
//    next tick runs normally; ERRCLR pulse -> TIMEOUT=0.
//  3 TIMEOUT=16, DONE 12 clk after START -> tick during WAIT sets OVERRUN, no extra LATCH;
//    exactly one POS_UPDATE, COUNT+1.
//  4 SETBEGIN low 20 clk in IDLE -> one POS_CLEAR_OutLow low pulse, COUNT=0;
//    pressed during WAIT -> pulse follows UPDATE, COUNT=0.
//  5 Reset_InLow low during WAIT -> all outputs at reset values that cycle;
//    after release first LATCH exactly PERIOD clk later.
//  6 COUNT preset to 0xFFFF via run -> next UPDATE gives 0; ENABLE dropped in WAIT -> sequence completes, then no ticks.

Source files
------------

// File: rtl/odom_scheduler_if.sv
// ---------------------------------------------------------------------------
// odom_scheduler_if
//  Control bundle between the odometry scheduler and its surroundings.
//  slave  : scheduler view (takes enable/button/done/error-clear, drives the
//           datapath strobes, status flags, sample count and debug state).
//  master : environment view (drives the inputs, observes the outputs).
//
//  Handshake semantics: there is no valid/ready pair here. GV_START_Out is a
//  one-cycle request to the global-velocity stage; GV_DONE_In is its level
//  completion flag and is only sampled while the scheduler is waiting for it.
//  LATCH_Out, POS_UPDATE_Out and POS_CLEAR_OutLow are single-cycle strobes
//  that the datapath must act on in the cycle they are asserted.
// ---------------------------------------------------------------------------
interface odom_scheduler_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ODOM_SCHEDULER_ENABLE_InHigh;
    logic                 ODOM_SCHEDULER_SETBEGIN_InLow;
    logic                 ODOM_SCHEDULER_GV_DONE_In;
    logic                 ODOM_SCHEDULER_ERRCLR_InHigh;
    logic                 ODOM_SCHEDULER_LATCH_Out;
    logic                 ODOM_SCHEDULER_GV_START_Out;
    logic                 ODOM_SCHEDULER_POS_UPDATE_Out;
    logic                 ODOM_SCHEDULER_POS_CLEAR_OutLow;
    logic                 ODOM_SCHEDULER_BUSY_Out;
    logic                 ODOM_SCHEDULER_OVERRUN_Out;
    logic                 ODOM_SCHEDULER_TIMEOUT_Out;
    logic [CNT_WIDTH-1:0] ODOM_SCHEDULER_SAMPLE_COUNT_OutBus;
    logic [2:0]           ODOM_SCHEDULER_STATE_OutBus;

    modport slave (
        input  ODOM_SCHEDULER_ENABLE_InHigh,
        input  ODOM_SCHEDULER_SETBEGIN_InLow,
        input  ODOM_SCHEDULER_GV_DONE_In,
        input  ODOM_SCHEDULER_ERRCLR_InHigh,
        output ODOM_SCHEDULER_LATCH_Out,
        output ODOM_SCHEDULER_GV_START_Out,
        output ODOM_SCHEDULER_POS_UPDATE_Out,
        output ODOM_SCHEDULER_POS_CLEAR_OutLow,
        output ODOM_SCHEDULER_BUSY_Out,
        output ODOM_SCHEDULER_OVERRUN_Out,
        output ODOM_SCHEDULER_TIMEOUT_Out,
        output ODOM_SCHEDULER_SAMPLE_COUNT_OutBus,
        output ODOM_SCHEDULER_STATE_OutBus
    );

    modport master (
        output ODOM_SCHEDULER_ENABLE_InHigh,
        output ODOM_SCHEDULER_SETBEGIN_InLow,
        output ODOM_SCHEDULER_GV_DONE_In,
        output ODOM_SCHEDULER_ERRCLR_InHigh,
        input  ODOM_SCHEDULER_LATCH_Out,
        input  ODOM_SCHEDULER_GV_START_Out,
        input  ODOM_SCHEDULER_POS_UPDATE_Out,
        input  ODOM_SCHEDULER_POS_CLEAR_OutLow,
        input  ODOM_SCHEDULER_BUSY_Out,
        input  ODOM_SCHEDULER_OVERRUN_Out,
        input  ODOM_SCHEDULER_TIMEOUT_Out,
        input  ODOM_SCHEDULER_SAMPLE_COUNT_OutBus,
        input  ODOM_SCHEDULER_STATE_OutBus
    );
endinterface

// File: rtl/odom_scheduler.sv
// ---------------------------------------------------------------------------
// odom_scheduler
//  Sequences the odometry datapath at a fixed sample rate: on each sample
//  tick it latches wheel speeds, starts the global-velocity rotation, waits
//  for its done flag (bounded by a timeout), then issues one integrate strobe
//  to the position calculator. The SETBEGIN button is synchronised and its
//  falling edge becomes a single position-clear pulse. Dropped ticks and
//  missing done flags are reported through sticky flags.
//
// Ports
//  ODOM_SCHEDULER_CLOCK_50     in  system clock
//  ODOM_SCHEDULER_Reset_InLow  in  asynchronous active-low reset
//  bus (odom_scheduler_if.slave):
//   ENABLE_InHigh, SETBEGIN_InLow, GV_DONE_In, ERRCLR_InHigh       inputs
//   LATCH_Out, GV_START_Out, POS_UPDATE_Out, POS_CLEAR_OutLow       strobes
//   BUSY_Out, OVERRUN_Out, TIMEOUT_Out, SAMPLE_COUNT_OutBus         status
//   STATE_OutBus                                                    debug
//
// Every output is a decode of registered state, so no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module odom_scheduler #(
    parameter int PERIOD_CYCLES  = 500000,
    parameter int PERIOD_WIDTH   = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_WIDTH       = 10,
    parameter int CNT_WIDTH      = 16
) (
    input  logic            ODOM_SCHEDULER_CLOCK_50,
    input  logic            ODOM_SCHEDULER_Reset_InLow,
    odom_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        stIdle   = 3'd0,
        stLatch  = 3'd1,
        stStart  = 3'd2,
        stWait   = 3'd3,
        stUpdate = 3'd4,
        stClear  = 3'd5
    } state_t;

    state_t                state;
    state_t                stateNext;

    logic [PERIOD_WIDTH-1:0] periodCnt;
    logic [TO_WIDTH-1:0]     toCnt;
    logic [CNT_WIDTH-1:0]    sampleCount;
    logic                    tick;
    logic                    toExpired;

    logic                    sbMeta;
    logic                    sbSync;
    logic                    sbPrev;
    logic                    sbFall;
    logic                    clearPending;

    logic                    overrunFlag;
    logic                    timeoutFlag;
    logic                    overrunSet;
    logic                    timeoutSet;

    // ---------------- sample-rate generator ----------------
    // Holding the counter at zero while disabled makes the first tick land
    // a full period after enable rises.
    assign tick = bus.ODOM_SCHEDULER_ENABLE_InHigh &&
                  (periodCnt == PERIOD_WIDTH'(PERIOD_CYCLES - 1));

    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            periodCnt <= '0;
        end else if (!bus.ODOM_SCHEDULER_ENABLE_InHigh || tick) begin
            periodCnt <= '0;
        end else begin
            periodCnt <= periodCnt + 1'b1;
        end
    end

    // ---------------- GV done timeout ----------------
    assign toExpired = (toCnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            toCnt <= '0;
        end else if (state == stStart) begin
            toCnt <= '0;
        end else if (state == stWait) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    // ---------------- SETBEGIN button ----------------
    // Sync registers reset high so releasing reset with the button idle
    // cannot look like a press.
    assign sbFall = sbPrev && !sbSync;

    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            sbMeta <= 1'b1;
            sbSync <= 1'b1;
            sbPrev <= 1'b1;
        end else begin
            sbMeta <= bus.ODOM_SCHEDULER_SETBEGIN_InLow;
            sbSync <= sbMeta;
            sbPrev <= sbSync;
        end
    end

    // A press during a sequence is remembered and serviced back in IDLE.
    // A fresh edge arriving in the CLEAR cycle is kept as a new request.
    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            clearPending <= 1'b0;
        end else if (sbFall) begin
            clearPending <= 1'b1;
        end else if (state == stClear) begin
            clearPending <= 1'b0;
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            state <= stIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            stIdle: begin
                if (clearPending) begin
                    stateNext = stClear;
                end else if (tick) begin
                    stateNext = stLatch;
                end
            end
            stLatch:  stateNext = stStart;
            stStart:  stateNext = stWait;
            stWait: begin
                // Done on the final timeout cycle still counts as success.
                if (bus.ODOM_SCHEDULER_GV_DONE_In) begin
                    stateNext = stUpdate;
                end else if (toExpired) begin
                    stateNext = stIdle;
                end
            end
            stUpdate: stateNext = stIdle;
            stClear:  stateNext = stIdle;
            default:  stateNext = stIdle;
        endcase
    end

    // ---------------- status ----------------
    // A tick is lost whenever IDLE is not about to accept it: either a
    // sequence is running or a pending clear takes priority.
    assign overrunSet = tick && ((state != stIdle) || clearPending);
    assign timeoutSet = (state == stWait) && !bus.ODOM_SCHEDULER_GV_DONE_In && toExpired;

    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            overrunFlag <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            if (overrunSet) begin
                overrunFlag <= 1'b1;
            end else if (bus.ODOM_SCHEDULER_ERRCLR_InHigh) begin
                overrunFlag <= 1'b0;
            end
            if (timeoutSet) begin
                timeoutFlag <= 1'b1;
            end else if (bus.ODOM_SCHEDULER_ERRCLR_InHigh) begin
                timeoutFlag <= 1'b0;
            end
        end
    end

    always_ff @(posedge ODOM_SCHEDULER_CLOCK_50 or negedge ODOM_SCHEDULER_Reset_InLow) begin
        if (!ODOM_SCHEDULER_Reset_InLow) begin
            sampleCount <= '0;
        end else if (state == stClear) begin
            sampleCount <= '0;
        end else if (state == stUpdate) begin
            sampleCount <= sampleCount + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign bus.ODOM_SCHEDULER_LATCH_Out           = (state == stLatch);
    assign bus.ODOM_SCHEDULER_GV_START_Out        = (state == stStart);
    assign bus.ODOM_SCHEDULER_POS_UPDATE_Out      = (state == stUpdate);
    assign bus.ODOM_SCHEDULER_POS_CLEAR_OutLow    = (state != stClear);
    assign bus.ODOM_SCHEDULER_BUSY_Out            = (state != stIdle);
    assign bus.ODOM_SCHEDULER_OVERRUN_Out         = overrunFlag;
    assign bus.ODOM_SCHEDULER_TIMEOUT_Out         = timeoutFlag;
    assign bus.ODOM_SCHEDULER_SAMPLE_COUNT_OutBus = sampleCount;
    assign bus.ODOM_SCHEDULER_STATE_OutBus        = state;

endmodule
